// File: rtl/usb_rx_phy.sv
// USB full-speed receive PHY: input synchroniser, bit-phase recovery, NRZI decode,
// SYNC detection, bit unstuffing, byte assembly and EOP / error detection.
module usb_rx_phy #(
    parameter int CLK_PER_BIT = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_48m,
    input  logic       rst_n,
    input  logic       usb_dp_rx,
    input  logic       usb_dn_rx,
    input  logic       rx_en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_active,
    output logic       rx_err,
    output logic       rx_eop,
    output logic [2:0] o_dbg_state
);
    localparam int PW = $clog2(CLK_PER_BIT);
    localparam logic [PW-1:0] HALF = PW'(CLK_PER_BIT / 2);
    localparam logic [PW-1:0] LAST = PW'(CLK_PER_BIT - 1);

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_EOP, S_RESYNC} state_t;
    typedef enum logic [1:0] {L_SE0 = 2'b00, L_K = 2'b01, L_J = 2'b10, L_SE1 = 2'b11} line_t;

    logic [SYNC_STAGES-1:0] r_dp_sync, r_dn_sync;
    line_t                  w_line, r_line_prev;
    logic [PW-1:0]          r_phase, w_phase;
    logic                   w_sample, w_jk, w_bit;

    state_t      r_state, w_state_n;
    logic [2:0]  r_bit_cnt, w_bit_cnt_n;
    logic [2:0]  r_ones, w_ones_n;
    logic [2:0]  r_j_cnt, w_j_cnt_n;
    logic        r_se0_two, w_se0_two_n;
    logic [7:0]  r_shift, w_shift_n;
    line_t       r_prev_jk, w_prev_jk_n;
    logic        w_valid, w_err, w_eop;

    always_ff @(posedge clk_48m or negedge rst_n) begin
        if (!rst_n) begin
            r_dp_sync <= '1;
            r_dn_sync <= '0;
        end else begin
            r_dp_sync <= {r_dp_sync[SYNC_STAGES-2:0], usb_dp_rx};
            r_dn_sync <= {r_dn_sync[SYNC_STAGES-2:0], usb_dn_rx};
        end
    end

    assign w_line = line_t'({r_dp_sync[SYNC_STAGES-1], r_dn_sync[SYNC_STAGES-1]});
    assign w_jk   = (w_line == L_J) || (w_line == L_K);
    assign w_bit  = (w_line == r_prev_jk);

    // The cycle in which a line change becomes visible counts as phase 0,
    // so the sample lands CLK_PER_BIT/2 cycles into each bit cell.
    assign w_phase  = (w_line != r_line_prev) ? '0 :
                      (r_phase == LAST)       ? '0 : r_phase + 1'b1;
    assign w_sample = (w_phase == HALF);

    always_ff @(posedge clk_48m or negedge rst_n) begin
        if (!rst_n) begin
            r_line_prev <= L_J;
            r_phase     <= '0;
        end else begin
            r_line_prev <= w_line;
            r_phase     <= w_phase;
        end
    end

    always_ff @(posedge clk_48m or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 3'd0;
            r_ones    <= 3'd0;
            r_j_cnt   <= 3'd0;
            r_se0_two <= 1'b0;
            r_shift   <= 8'h00;
            r_prev_jk <= L_J;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            rx_err    <= 1'b0;
            rx_eop    <= 1'b0;
            rx_active <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_bit_cnt <= w_bit_cnt_n;
            r_ones    <= w_ones_n;
            r_j_cnt   <= w_j_cnt_n;
            r_se0_two <= w_se0_two_n;
            r_shift   <= w_shift_n;
            r_prev_jk <= w_prev_jk_n;
            rx_valid  <= w_valid;
            rx_err    <= w_err;
            rx_eop    <= w_eop;
            rx_active <= (w_state_n == S_DATA) || (w_state_n == S_EOP);
            if (w_valid) rx_data <= w_shift_n;
        end
    end

    // The stuffing run counter starts at zero when DATA is entered.
    always_comb begin
        w_state_n   = r_state;
        w_bit_cnt_n = r_bit_cnt;
        w_ones_n    = r_ones;
        w_j_cnt_n   = (r_state == S_RESYNC) ? r_j_cnt : 3'd0;
        w_se0_two_n = r_se0_two;
        w_shift_n   = r_shift;
        w_prev_jk_n = r_prev_jk;
        w_valid     = 1'b0;
        w_err       = 1'b0;
        w_eop       = 1'b0;
        if (!rx_en) begin
            w_state_n   = S_IDLE;
            w_bit_cnt_n = 3'd0;
            w_ones_n    = 3'd0;
            w_j_cnt_n   = 3'd0;
            w_se0_two_n = 1'b0;
            w_prev_jk_n = L_J;
        end else if (w_sample) begin
            if (w_jk) w_prev_jk_n = w_line;
            case (r_state)
                S_IDLE: begin
                    if (w_line == L_K) begin
                        w_state_n   = S_SYNC;
                        w_bit_cnt_n = 3'd1;
                    end
                end
                S_SYNC: begin
                    if (w_line == L_SE1) begin
                        w_err     = 1'b1;
                        w_state_n = S_RESYNC;
                    end else if (!w_jk) begin
                        w_state_n = S_RESYNC;
                    end else if (r_bit_cnt == 3'd7) begin
                        if (w_bit) begin
                            w_state_n   = S_DATA;
                            w_bit_cnt_n = 3'd0;
                            w_ones_n    = 3'd0;
                        end else begin
                            w_state_n = S_RESYNC;
                        end
                    end else if (w_bit) begin
                        w_state_n = S_RESYNC;
                    end else begin
                        w_bit_cnt_n = r_bit_cnt + 3'd1;
                    end
                end
                S_DATA: begin
                    if (w_line == L_SE1) begin
                        w_err     = 1'b1;
                        w_state_n = S_RESYNC;
                    end else if (w_line == L_SE0) begin
                        if (r_bit_cnt != 3'd0) begin
                            w_err     = 1'b1;
                            w_state_n = S_RESYNC;
                        end else begin
                            w_state_n   = S_EOP;
                            w_se0_two_n = 1'b0;
                        end
                    end else if (r_ones == 3'd6) begin
                        if (w_bit) begin
                            w_err     = 1'b1;
                            w_state_n = S_RESYNC;
                        end else begin
                            w_ones_n = 3'd0;
                        end
                    end else begin
                        w_ones_n    = w_bit ? r_ones + 3'd1 : 3'd0;
                        w_shift_n   = {w_bit, r_shift[7:1]};
                        w_bit_cnt_n = r_bit_cnt + 3'd1;
                        w_valid     = (r_bit_cnt == 3'd7);
                    end
                end
                S_EOP: begin
                    if (w_line == L_SE0) begin
                        if (r_se0_two) begin
                            w_err     = 1'b1;
                            w_state_n = S_RESYNC;
                        end else begin
                            w_se0_two_n = 1'b1;
                        end
                    end else if ((w_line == L_J) && r_se0_two) begin
                        w_eop     = 1'b1;
                        w_state_n = S_IDLE;
                    end else begin
                        w_err     = 1'b1;
                        w_state_n = S_RESYNC;
                    end
                end
                S_RESYNC: begin
                    if (w_line == L_J) begin
                        if (r_j_cnt == 3'd6) begin
                            w_state_n = S_IDLE;
                            w_j_cnt_n = 3'd0;
                        end else begin
                            w_j_cnt_n = r_j_cnt + 3'd1;
                        end
                    end else begin
                        w_j_cnt_n = 3'd0;
                        w_err     = (w_line == L_SE1);
                    end
                end
                default: w_state_n = S_IDLE;
            endcase
        end
    end

    assign o_dbg_state = r_state;

endmodule

// File: doc/usb_rx_phy.md
USB_RX_PHY -- requirements
Module: usb_rx_phy

Interface
REQ-001 The block SHALL have parameter CLK_PER_BIT, default 4, meaning system clocks per USB bit (4 for FS at 48 MHz); legal values are even numbers 4..16.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning the flip-flop depth of the input synchroniser; legal values are 2..4.
REQ-003 The block SHALL have port clk_48m  input  1  system clock.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port usb_dp_rx  input  1  raw D+ line from frontend.
REQ-006 The block SHALL have port usb_dn_rx  input  1  raw D- line from frontend.
REQ-007 The block SHALL have port rx_en  input  1  receive enable (low while the device transmits).
REQ-008 The block SHALL have port rx_data  output  8  received byte, LSB = first bit on the wire.
REQ-009 The block SHALL have port rx_valid  output  1  one-cycle strobe qualifying rx_data.
REQ-010 The block SHALL have port rx_active  output  1  high from SYNC completion until end of packet.
REQ-011 The block SHALL have port rx_err  output  1  one-cycle strobe on a packet error.
REQ-012 The block SHALL have port rx_eop  output  1  one-cycle strobe on a valid end of packet.

Function
REQ-013 The block SHALL pass each of usb_dp_rx and usb_dn_rx through SYNC_STAGES flops before any use.
REQ-014 The block SHALL decode the line state as J=(dp=1,dn=0), K=(0,1), SE0=(0,0), SE1=(1,1).
REQ-015 The block SHALL run a bit-phase counter modulo CLK_PER_BIT that reloads to 0 on every J/K transition and samples the line when the count equals CLK_PER_BIT/2.
REQ-016 The block SHALL NRZI-decode each sample: the same J/K as the previous sample gives 1, and a change gives 0.
REQ-017 The block SHALL implement states IDLE, SYNC, DATA, EOP and RESYNC, and SHALL enter IDLE on reset.
REQ-018 In IDLE, the first K sample SHALL move the block to SYNC, which previous-sample J.
REQ-019 SYNC SHALL match the decoded pattern 0000_0001, which after IDLE J is the line sequence KJKJKJKK; on a match the block SHALL enter DATA and assert rx_active on the next cycle.
REQ-020 A SYNC mismatch SHALL move the block to RESYNC without asserting rx_err.
REQ-021 In DATA, the block SHALL count consecutive decoded 1s (saturating at 6); the bit following six 1s SHALL be discarded if 0, and its count SHALL reset to 0.
REQ-022 If the bit following six 1s is 1, the block SHALL pulse rx_err, drop rx_active and enter RESYNC.
REQ-023 DATA SHALL shift non-stuffed bits LSB-first into an 8-bit register; on the 8th bit, rx_data SHALL update and rx_valid SHALL pulse for exactly one cycle.
REQ-024 An SE0 sample in DATA SHALL move the block to EOP; a further SE0 sample followed by a J sample SHALL pulse rx_eop, drop rx_active and enter IDLE.
REQ-025 At EOP entry, if the bit count is non-zero (partial byte), the block SHALL pulse rx_err instead of rx_eop, and the partial byte SHALL NOT be presented.
REQ-026 A single SE0 sample followed by K, a third consecutive SE0, or an SE1 sample in any state other than IDLE SHALL pulse rx_err, drop rx_active and enter RESYNC.
REQ-027 RESYNC SHALL wait for 7 consecutive J samples (bus idle) and then enter IDLE.
REQ-028 Deasserting rx_en SHALL force IDLE within one cycle, with no rx_err, rx_eop or rx_valid strobe; while rx_en is low, all strobes SHALL stay 0.
REQ-029 rx_valid, rx_err and rx_eop SHALL be mutually exclusive in any cycle; where they conflict, rx_err SHALL have priority.
REQ-030 The delay from the sampling edge of the 8th data bit to rx_valid SHALL be exactly 1 clock.

Reset
REQ-031 While rst_n is low, rx_data SHALL be 8'h00, rx_valid, rx_active, rx_err and rx_eop SHALL be 0, the state SHALL be IDLE, and the counters and synchroniser flops SHALL be cleared (synchroniser to J).
REQ-032 Reset asserted mid-packet SHALL abort it with no strobe; after release, the block SHALL need a full SYNC to receive again.

Verification
REQ-033 CLK_PER_BIT=4: idle J, SYNC, bytes 8'hA5 then 8'h3C, SE0 SE0 J -> rx_valid twice with rx_data 8'hA5 then 8'h3C, one rx_eop, and rx_active high only between SYNC end and EOP.
REQ-034 Byte 8'hFF,8'h01 with correct stuffing (0 after six 1s) -> rx_data 8'hFF then 8'h01, no rx_err.
REQ-035 Seven consecutive decoded 1s in DATA -> rx_err pulse, rx_active low, and no rx_valid until a new SYNC after 7 J samples.
REQ-036 SYNC, then 5 data bits, then SE0 SE0 J -> rx_err pulse, no rx_valid, no rx_eop.
REQ-037 CLK_PER_BIT=8 with ±1-clock jitter on every edge -> payload 8'h5A received correctly.
REQ-038 rx_en deasserted mid-byte, and separately rst_n pulsed mid-byte -> no strobes and rx_active 0; the next full packet is received correctly.
